// File: rtl/sram_weight_bank.sv
// Weight SRAM for the conv engine: masked direct writes, READ_LAT-deep read pipeline with
// rvalid, and a streaming valid/ready loader. Define SRAM_BYPASS_EN for write-to-read forwarding.
module sram_weight_bank #(
  parameter int WEIGHT_WIDTH = 4,
  parameter int WEIGHT_NUM   = 25,
  parameter int DEPTH        = 20000,
  parameter int READ_LAT     = 1,
  parameter int AW           = 15,
  localparam int DATA_WIDTH  = WEIGHT_WIDTH * WEIGHT_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb,
  input  logic                  wsb,
  input  logic [WEIGHT_NUM-1:0] wmask,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  ld_start,
  input  logic [AW-1:0]         ld_base,
  input  logic [AW:0]           ld_len,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} ld_state_t;

  ld_state_t             r_state;
  logic [AW-1:0]         r_ptr;
  logic [AW:0]           r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_pipe_data [READ_LAT];
  logic [READ_LAT-1:0]   r_pipe_vld;

  logic                  w_dir_req;
  logic                  w_dir_we;
  logic                  w_ld_acc;
  logic                  w_we;
  logic [AW-1:0]         w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [WEIGHT_NUM-1:0] w_wr_mask;
  logic                  w_rd_ok;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // A direct write request stalls the loader even when its address is out of range.
  assign w_dir_req = ~csb & ~wsb;
  assign w_dir_we  = w_dir_req && (waddr <= LAST_ADDR);
  assign ld_ready  = (r_state == S_LOAD) && !w_dir_req;
  assign w_ld_acc  = ld_ready && ld_valid;
  assign w_we      = w_dir_we | w_ld_acc;
  assign w_wr_addr = w_ld_acc ? r_ptr : waddr;
  assign w_wr_data = w_ld_acc ? ld_data : wdata;
  assign w_wr_mask = w_ld_acc ? '1 : wmask;

  assign ld_busy = (r_state != S_IDLE);
  assign ld_done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < WEIGHT_NUM; i++) begin
        if (w_wr_mask[i]) r_mem[w_wr_addr][i*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= w_wr_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  assign w_rd_ok  = (raddr <= LAST_ADDR);
  assign w_rd_old = r_mem[raddr];

`ifdef SRAM_BYPASS_EN
  genvar gi;
  generate
    for (gi = 0; gi < WEIGHT_NUM; gi++) begin : g_bypass
      assign w_rd_word[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
        (w_we && (w_wr_addr == raddr) && w_wr_mask[gi]) ? w_wr_data[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]
                                                        : w_rd_old[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  endgenerate
`else
  assign w_rd_word = w_rd_old;
`endif

  // Each stage only advances on a valid beat, so rdata holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < READ_LAT; k++) r_pipe_data[k] <= '0;
    end else begin
      r_pipe_vld[0] <= ~csb;
      if (~csb) r_pipe_data[0] <= w_rd_ok ? w_rd_word : '0;
      for (int k = 1; k < READ_LAT; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) r_pipe_data[k] <= r_pipe_data[k-1];
      end
    end
  end

  assign rdata  = r_pipe_data[READ_LAT-1];
  assign rvalid = r_pipe_vld[READ_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld_start) begin
            r_ptr   <= (ld_base <= LAST_ADDR) ? ld_base : '0;
            r_cnt   <= ld_len;
            r_state <= (ld_len != '0) ? S_LOAD : S_DONE;
          end
        end
        S_LOAD: begin
          if (w_ld_acc) begin
            r_ptr <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == (AW+1)'(1)) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_weight_bank.sv
// Directed bench for sram_weight_bank: a READ_LAT=1 and a READ_LAT=3 instance share all inputs.
module tb_sram_weight_bank;
  localparam int AW = 15;
  localparam int DW = 100;
  localparam int WN = 25;
  localparam int DEPTH = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          csb, wsb;
  logic [WN-1:0] wmask;
  logic [AW-1:0] waddr, raddr, ld_base;
  logic [DW-1:0] wdata, ld_data;
  logic [AW:0]   ld_len;
  logic          ld_start, ld_valid;

  logic [DW-1:0] rdata1, rdata3;
  logic          rvalid1, rvalid3;
  logic          ld_ready1, ld_busy1, ld_done1;
  logic          ld_ready3, ld_busy3, ld_done3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_weight_bank #(.READ_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .csb(csb), .wsb(wsb), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .ld_start(ld_start), .ld_base(ld_base),
    .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready1),
    .ld_busy(ld_busy1), .ld_done(ld_done1)
  );

  sram_weight_bank #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .csb(csb), .wsb(wsb), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata3), .rvalid(rvalid3), .ld_start(ld_start), .ld_base(ld_base),
    .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready3),
    .ld_busy(ld_busy3), .ld_done(ld_done3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WN-1:0] m);
    csb = 1'b0; wsb = 1'b0; waddr = a; wdata = d; wmask = m;
    tick();
    csb = 1'b1; wsb = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    csb = 1'b0; wsb = 1'b1; raddr = a;
    tick();
    d = rdata1;
    csb = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; csb = 1'b1; wsb = 1'b1; wmask = '1; waddr = '0; raddr = '0; wdata = '0;
    ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    repeat (3) tick();
    n_checks++; if (rdata1 !== '0) begin $display("FAIL reset_rdata: got %h expected 0", rdata1); n_fail++; end
    n_checks++; if ({rvalid1, rvalid3} !== 2'b00) begin $display("FAIL reset_rvalid: got %b expected 00", {rvalid1, rvalid3}); n_fail++; end
    n_checks++; if ({ld_ready1, ld_busy1, ld_done1} !== 3'b000) begin $display("FAIL reset_loader: got %b expected 000", {ld_ready1, ld_busy1, ld_done1}); n_fail++; end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_rw;
    logic [DW-1:0] d;
    raddr = 15'd6;
    wr(15'd5, 100'hA5, '1);
    rd(15'd5, d);
    n_checks++; if (d !== 100'hA5) begin $display("FAIL basic_rdata: got %h expected %h", d, 100'hA5); n_fail++; end
    n_checks++; if (rvalid1 !== 1'b1) begin $display("FAIL basic_rvalid_hi: got %b expected 1", rvalid1); n_fail++; end
    tick();
    n_checks++; if (rvalid1 !== 1'b0) begin $display("FAIL basic_rvalid_lo: got %b expected 0", rvalid1); n_fail++; end
    n_checks++; if (rdata1 !== 100'hA5) begin $display("FAIL basic_rdata_hold: got %h expected %h", rdata1, 100'hA5); n_fail++; end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 100'h111; exp_d[1] = 100'h222; exp_d[2] = 100'h333;
    raddr = 15'd0;
    for (int i = 0; i < 3; i++) wr(AW'(i), exp_d[i], '1);
    repeat (4) tick();
    for (int k = 0; k < 7; k++) begin
      csb = (k < 3) ? 1'b0 : 1'b1; wsb = 1'b1; raddr = AW'(k);
      tick();
      n_checks++;
      if (rvalid3 !== ((k >= 2) && (k <= 4))) begin $display("FAIL lat3_rvalid step %0d: got %b expected %b", k, rvalid3, (k >= 2) && (k <= 4)); n_fail++; end
      if (k >= 2 && k <= 4) begin
        n_checks++; if (rdata3 !== exp_d[k-2]) begin $display("FAIL lat3_rdata step %0d: got %h expected %h", k, rdata3, exp_d[k-2]); n_fail++; end
      end
      if (k < 3) begin
        n_checks++; if (rdata1 !== exp_d[k] || rvalid1 !== 1'b1) begin $display("FAIL lat1_stream step %0d: got %h/%b expected %h/1", k, rdata1, rvalid1, exp_d[k]); n_fail++; end
      end
    end
  endtask

  task automatic test_range_and_mask;
    logic [DW-1:0] d;
    rd(AW'(DEPTH), d);
    n_checks++; if (d !== '0) begin $display("FAIL oob_read: got %h expected 0", d); n_fail++; end
    raddr = 15'd0;
    wr(15'd7, {25{4'h3}}, '1);
    wr(15'd7, {25{4'hF}}, 25'h1);
    rd(15'd7, d);
    n_checks++; if (d !== {{24{4'h3}}, 4'hF}) begin $display("FAIL mask_w0: got %h expected %h", d, {{24{4'h3}}, 4'hF}); n_fail++; end
    wr(15'd7, '0, 25'h1000000);
    rd(15'd7, d);
    n_checks++; if (d !== {4'h0, {23{4'h3}}, 4'hF}) begin $display("FAIL mask_w24: got %h expected %h", d, {4'h0, {23{4'h3}}, 4'hF}); n_fail++; end
  endtask

  task automatic test_loader_wrap;
    logic [DW-1:0] lw [4];
    logic [11:0]   vpat = 12'b0000_0110_0101;
    logic [DW-1:0] d;
    int idx = 0;
    int done_cnt = 0;
    lw[0] = 100'hD0D0; lw[1] = 100'hD1D1; lw[2] = 100'hD2D2; lw[3] = 100'hD3D3;
    ld_start = 1'b1; ld_base = AW'(DEPTH - 2); ld_len = 16'd4;
    tick();
    ld_start = 1'b0;
    n_checks++; if (ld_busy1 !== 1'b1 || ld_ready1 !== 1'b1) begin $display("FAIL wrap_start: got busy %b ready %b expected 1 1", ld_busy1, ld_ready1); n_fail++; end
    for (int s = 0; s < 12; s++) begin
      ld_valid = vpat[s] && (idx < 4);
      ld_data  = lw[idx % 4];
      if (ld_valid) idx++;
      tick();
      if (ld_done1) done_cnt++;
    end
    ld_valid = 1'b0;
    n_checks++; if (done_cnt != 1) begin $display("FAIL wrap_done_pulses: got %0d expected 1", done_cnt); n_fail++; end
    n_checks++; if (ld_busy1 !== 1'b0) begin $display("FAIL wrap_busy_end: got %b expected 0", ld_busy1); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      rd(AW'((DEPTH - 2 + i) % DEPTH), d);
      n_checks++; if (d !== lw[i]) begin $display("FAIL wrap_word %0d: got %h expected %h", i, d, lw[i]); n_fail++; end
    end
  endtask

  task automatic test_loader_stall;
    logic [DW-1:0] d;
    ld_start = 1'b1; ld_base = 15'd100; ld_len = 16'd2;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 100'hE0;
    csb = 1'b0; wsb = 1'b0; waddr = 15'd200; wdata = 100'hC0; wmask = '1;
    #1;
    n_checks++; if (ld_ready1 !== 1'b0) begin $display("FAIL stall_ready_lo: got %b expected 0", ld_ready1); n_fail++; end
    tick();
    csb = 1'b1; wsb = 1'b1;
    #1;
    n_checks++; if (ld_ready1 !== 1'b1) begin $display("FAIL stall_ready_hi: got %b expected 1", ld_ready1); n_fail++; end
    tick();
    ld_data = 100'hE1;
    tick();
    ld_valid = 1'b0;
    n_checks++; if (ld_done1 !== 1'b1) begin $display("FAIL stall_done: got %b expected 1", ld_done1); n_fail++; end
    tick();
    rd(15'd100, d);
    n_checks++; if (d !== 100'hE0) begin $display("FAIL stall_word0: got %h expected %h", d, 100'hE0); n_fail++; end
    rd(15'd101, d);
    n_checks++; if (d !== 100'hE1) begin $display("FAIL stall_word1: got %h expected %h", d, 100'hE1); n_fail++; end
    rd(15'd200, d);
    n_checks++; if (d !== 100'hC0) begin $display("FAIL stall_direct: got %h expected %h", d, 100'hC0); n_fail++; end
  endtask

  task automatic test_loader_abort_zero;
    logic [DW-1:0] d;
    ld_start = 1'b1; ld_base = 15'd300; ld_len = 16'd3;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 100'hF0;
    tick();
    ld_valid = 1'b0;
    n_checks++; if (ld_busy1 !== 1'b1) begin $display("FAIL abort_busy_pre: got %b expected 1", ld_busy1); n_fail++; end
    rst = 1'b1;
    tick();
    n_checks++; if (ld_busy1 !== 1'b0 || ld_ready1 !== 1'b0) begin $display("FAIL abort_busy: got busy %b ready %b expected 0 0", ld_busy1, ld_ready1); n_fail++; end
    rst = 1'b0;
    rd(15'd300, d);
    n_checks++; if (d !== 100'hF0) begin $display("FAIL abort_kept: got %h expected %h", d, 100'hF0); n_fail++; end
    ld_start = 1'b1; ld_len = '0;
    tick();
    ld_start = 1'b0;
    n_checks++; if (ld_done1 !== 1'b1 || ld_busy1 !== 1'b1) begin $display("FAIL zero_len_done: got done %b busy %b expected 1 1", ld_done1, ld_busy1); n_fail++; end
    tick();
    n_checks++; if (ld_done1 !== 1'b0 || ld_busy1 !== 1'b0) begin $display("FAIL zero_len_idle: got done %b busy %b expected 0 0", ld_done1, ld_busy1); n_fail++; end
    ld_start = 1'b1; ld_base = AW'(DEPTH + 5); ld_len = 16'd1;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 100'h77;
    tick();
    ld_valid = 1'b0;
    tick();
    rd(15'd0, d);
    n_checks++; if (d !== 100'h77) begin $display("FAIL base_clamp: got %h expected %h", d, 100'h77); n_fail++; end
  endtask

  task automatic test_collision;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_c;
`ifdef SRAM_BYPASS_EN
    exp_c = 100'hBB;
`else
    exp_c = 100'hAA;
`endif
    raddr = 15'd0;
    wr(15'd9, 100'hAA, '1);
    csb = 1'b0; wsb = 1'b0; waddr = 15'd9; wdata = 100'hBB; wmask = '1; raddr = 15'd9;
    tick();
    csb = 1'b1; wsb = 1'b1;
    n_checks++; if (rdata1 !== exp_c) begin $display("FAIL collide_read: got %h expected %h", rdata1, exp_c); n_fail++; end
    rd(15'd9, d);
    n_checks++; if (d !== 100'hBB) begin $display("FAIL collide_landed: got %h expected %h", d, 100'hBB); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_back_to_back();
    test_range_and_mask();
    test_loader_wrap();
    test_loader_stall();
    test_loader_abort_zero();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
